// File: rtl/time_sync_pkg.sv
// Shared constants for the host time-set frame receiver: frame layout,
// error codes and controller state encoding.
package time_sync_pkg;

    localparam logic [7:0] SYNC_HDR         = 8'hA5;
    localparam int         FRAME_DATA_BYTES = 8;

    localparam logic [1:0] ERR_CHKSUM  = 2'b01;
    localparam logic [1:0] ERR_BYTE_TO = 2'b10;
    localparam logic [1:0] ERR_PPS_TO  = 2'b11;

    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_DATA_ENC = 3'd1;
    localparam logic [2:0] ST_CHK_ENC  = 3'd2;
    localparam logic [2:0] ST_ARM_ENC  = 3'd3;
    localparam logic [2:0] ST_LOAD_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_DATA = ST_DATA_ENC,
        ST_CHK  = ST_CHK_ENC,
        ST_ARM  = ST_ARM_ENC,
        ST_LOAD = ST_LOAD_ENC
    } state_t;

endpackage

// File: rtl/time_sync_pps_edge_sync.sv
// Brings the asynchronous PPS input into the 50 MHz domain through a
// flop chain and emits a one-cycle pulse on each synchronized rising edge.
module pps_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk_50m,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], i_async};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    // Rising edge of the synchronized level
    always_comb begin
        o_rise = sync_reg[STAGES-1] & ~prev_reg;
    end

endmodule

// File: rtl/time_sync_ctrl.sv
// Host time-set frame receiver feeding the timestamp counter.
// Frame: A5, 8 data bytes MSB first, XOR checksum of the data bytes.
// Build option TIME_SYNC_PPS_EN: defer the load to the next PPS rising edge.
module time_sync_ctrl
    import time_sync_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 50_000,
    parameter int PPS_TIMEOUT  = 100_000_000
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    input  logic [7:0]  i_cmd_data,
    output logic        o_cmd_ready,
    input  logic        i_pps,
    output logic        o_time_stamp_sig,
    output logic [63:0] o_time_stamp_set,
    output logic        o_sync_err,
    output logic [1:0]  o_err_code,
    output logic [15:0] o_sync_cnt
);

    localparam int             BT_W    = $clog2(BYTE_TIMEOUT);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [3:0]      IDX_CS  = 4'(FRAME_DATA_BYTES);

    state_t          state_reg, state_next;
    logic            accept;
    logic [63:0]     shift_reg;
    logic [63:0]     set_reg;
    logic [7:0]      xor_reg;
    logic [7:0]      cs_reg;
    logic [3:0]      idx_reg;
    logic [BT_W-1:0] byte_tmr_reg;
    logic [15:0]     cnt_reg;
    logic            err_reg;
    logic [1:0]      err_code_reg;
    logic            err_fire;
    logic [1:0]      err_kind;
    logic            ready;
    logic            load_sig;

`ifdef TIME_SYNC_PPS_EN
    localparam int             PT_W    = $clog2(PPS_TIMEOUT);
    localparam logic [PT_W-1:0] PT_LAST = PT_W'(PPS_TIMEOUT - 1);

    logic [PT_W-1:0] pps_tmr_reg;
    logic            pps_rise;

    pps_edge_sync #(.STAGES(2)) u_pps_edge_sync (
        .i_clk_50m (i_clk_50m),
        .i_rst_n   (i_rst_n),
        .i_async   (i_pps),
        .o_rise    (pps_rise)
    );

    // Cycles spent waiting for PPS; restarts every time ARM is entered
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pps_tmr_reg <= '0;
        end else if (state_reg == ST_ARM) begin
            pps_tmr_reg <= pps_tmr_reg + PT_W'(1);
        end else begin
            pps_tmr_reg <= '0;
        end
    end
`else
    // PPS input and its timeout have no function in this build
    logic unused_pps_cfg;
    assign unused_pps_cfg = i_pps ^ PPS_TIMEOUT[0];
`endif

    assign accept = i_cmd_valid & ready;

    // State register
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decision, including which error (if any) ends the frame
    always_comb begin
        state_next = state_reg;
        err_fire   = 1'b0;
        err_kind   = ERR_CHKSUM;
        case (state_reg)
            ST_IDLE: begin
                if (accept && i_cmd_data == SYNC_HDR) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (accept) begin
                    if (idx_reg == IDX_CS) state_next = ST_CHK;
                end else if (byte_tmr_reg == BT_LAST) begin
                    state_next = ST_IDLE;
                    err_fire   = 1'b1;
                    err_kind   = ERR_BYTE_TO;
                end
            end
            ST_CHK: begin
                if (cs_reg == xor_reg) begin
`ifdef TIME_SYNC_PPS_EN
                    state_next = ST_ARM;
`else
                    state_next = ST_LOAD;
`endif
                end else begin
                    state_next = ST_IDLE;
                    err_fire   = 1'b1;
                    err_kind   = ERR_CHKSUM;
                end
            end
`ifdef TIME_SYNC_PPS_EN
            ST_ARM: begin
                if (pps_rise) begin
                    state_next = ST_LOAD;
                end else if (pps_tmr_reg == PT_LAST) begin
                    state_next = ST_IDLE;
                    err_fire   = 1'b1;
                    err_kind   = ERR_PPS_TO;
                end
            end
`endif
            ST_LOAD: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Moore outputs: stall the byte stream after the checksum, strobe in LOAD
    always_comb begin
        ready    = !(state_reg == ST_CHK || state_reg == ST_ARM || state_reg == ST_LOAD);
        load_sig = (state_reg == ST_LOAD);
    end

    // Frame assembly, byte timer, loaded value, counters and error reporting
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_reg    <= '0;
            xor_reg      <= '0;
            cs_reg       <= '0;
            idx_reg      <= '0;
            byte_tmr_reg <= '0;
            set_reg      <= '0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= '0;
        end else begin
            err_reg <= err_fire;
            if (err_fire) err_code_reg <= err_kind;

            case (state_reg)
                ST_IDLE: begin
                    if (accept && i_cmd_data == SYNC_HDR) begin
                        idx_reg      <= '0;
                        xor_reg      <= '0;
                        byte_tmr_reg <= '0;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        byte_tmr_reg <= '0;
                        if (idx_reg != IDX_CS) begin
                            shift_reg <= {shift_reg[55:0], i_cmd_data};
                            xor_reg   <= xor_reg ^ i_cmd_data;
                            idx_reg   <= idx_reg + 4'd1;
                        end else begin
                            cs_reg <= i_cmd_data;
                        end
                    end else begin
                        byte_tmr_reg <= byte_tmr_reg + BT_W'(1);
                    end
                end
                default: ;
            endcase

            // Value is captured on entry to LOAD so it is valid alongside the strobe
            if (state_next == ST_LOAD && state_reg != ST_LOAD) begin
                set_reg <= shift_reg;
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign o_cmd_ready      = ready;
    assign o_time_stamp_sig = load_sig;
    assign o_time_stamp_set = set_reg;
    assign o_sync_err       = err_reg;
    assign o_err_code       = err_code_reg;
    assign o_sync_cnt       = cnt_reg;

endmodule
